// File: rtl/nmr_bstrm_pkg.sv
// nmr_bstrm_pkg: sequencer state encoding and pulse-entry layout {pol, sel, len}
package nmr_bstrm_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_WAIT_RDY, S_RUN, S_GAP, S_ABORT, S_FINISH
  } bstrm_seq_state_t;
  localparam int ENTRY_LEN_LSB = 0;
  function automatic int entry_sel_lsb(input int dw);
    return dw;
  endfunction
  function automatic int entry_pol_bit(input int dw, input int sw);
    return dw + sw;
  endfunction
  function automatic int entry_width(input int dw, input int sw);
    return dw + sw + 1;
  endfunction
endpackage

// File: rtl/nmr_bstrm_seq_ctrl.sv
// nmr_bstrm_seq_ctrl: walks a pulse table and runs the START/RDY/DONE handshake with the datapath
module nmr_bstrm_seq_ctrl
  import nmr_bstrm_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int LOOP_WIDTH = 16
) (
  input  logic                                         CLK,
  input  logic                                         RST,
  input  logic                                         seq_start,
  input  logic                                         seq_abort,
  input  logic [ADDR_WIDTH:0]                          seq_len,
  input  logic [LOOP_WIDTH-1:0]                        loop_cnt,
  output logic                                         busy,
  output logic                                         seq_done,
  output logic                                         aborted,
  output logic [ADDR_WIDTH-1:0]                        cur_idx,
  output logic [LOOP_WIDTH-1:0]                        loops_done,
  output logic                                         mem_rd,
  output logic [ADDR_WIDTH-1:0]                        mem_addr,
  input  logic [entry_width(DATA_WIDTH, SEL_WIDTH)-1:0] mem_rdata,
  output logic                                         dp_start,
  input  logic                                         dp_rdy,
  input  logic                                         dp_done,
  output logic [DATA_WIDTH-1:0]                        dp_data,
  output logic                                         dp_pls_pol,
  output logic [SEL_WIDTH-1:0]                         dp_mux_sel
);
  localparam int SEL_LSB = entry_sel_lsb(DATA_WIDTH);
  localparam int POL_BIT = entry_pol_bit(DATA_WIDTH, SEL_WIDTH);
  localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  bstrm_seq_state_t r_state;
  logic r_busy, r_done, r_aborted, r_ab, r_mem_rd, r_dp_start, r_pol;
  logic [ADDR_WIDTH-1:0] r_cur, r_last;
  logic [LOOP_WIDTH-1:0] r_loops, r_loop_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SEL_WIDTH-1:0] r_sel;
  logic [ADDR_WIDTH-1:0] w_last;
  logic [LOOP_WIDTH:0] w_loops_inc;
  logic w_more_loops, w_abort;
  always_comb begin
    w_last       = (seq_len > LEN_MAX) ? '1 : ADDR_WIDTH'(seq_len - 1'b1);
    w_loops_inc  = {1'b0, r_loops} + 1'b1;
    w_more_loops = (r_loop_cnt == '0) || (w_loops_inc < {1'b0, r_loop_cnt});
    w_abort      = seq_abort && r_busy && r_state != S_ABORT && r_state != S_FINISH;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_ab       <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_dp_start <= 1'b0;
      r_pol      <= 1'b0;
      r_cur      <= '0;
      r_last     <= '0;
      r_loops    <= '0;
      r_loop_cnt <= '0;
      r_data     <= '0;
      r_sel      <= '0;
    end else begin
      r_mem_rd <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: if (seq_start) begin
          r_busy     <= 1'b1;
          r_aborted  <= 1'b0;
          r_ab       <= 1'b0;
          r_cur      <= '0;
          r_loops    <= '0;
          r_loop_cnt <= loop_cnt;
          r_last     <= w_last;
          r_mem_rd   <= seq_len != '0;
          r_state    <= (seq_len == '0) ? S_FINISH : S_FETCH;
        end
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_data  <= mem_rdata[ENTRY_LEN_LSB +: DATA_WIDTH];
          r_sel   <= mem_rdata[SEL_LSB +: SEL_WIDTH];
          r_pol   <= mem_rdata[POL_BIT];
          r_state <= S_WAIT_RDY;
        end
        S_WAIT_RDY: if (dp_rdy) begin
          r_dp_start <= 1'b1;
          r_state    <= S_RUN;
        end
        S_RUN: if (dp_done) begin
          r_dp_start <= 1'b0;
          r_state    <= S_GAP;
        end
        S_GAP: if (r_cur != r_last) begin
          r_cur    <= r_cur + 1'b1;
          r_mem_rd <= 1'b1;
          r_state  <= S_FETCH;
        end else begin
          // finite runs stop before saturation matters; infinite runs wrap
          r_cur    <= '0;
          r_loops  <= (r_loop_cnt != '0 && &r_loops) ? r_loops : w_loops_inc[LOOP_WIDTH-1:0];
          r_mem_rd <= w_more_loops;
          r_state  <= w_more_loops ? S_FETCH : S_FINISH;
        end
        S_ABORT: if (dp_rdy) begin
          r_ab    <= 1'b1;
          r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_aborted <= r_ab;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // abort overrides any transition above, including a coincident dp_done
      if (w_abort) begin
        r_state    <= S_ABORT;
        r_dp_start <= 1'b0;
        r_mem_rd   <= 1'b0;
      end
    end
  end
  assign busy       = r_busy;
  assign seq_done   = r_done;
  assign aborted    = r_aborted;
  assign cur_idx    = r_cur;
  assign loops_done = r_loops;
  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_cur;
  assign dp_start   = r_dp_start;
  assign dp_data    = r_data;
  assign dp_pls_pol = r_pol;
  assign dp_mux_sel = r_sel;
endmodule

// File: tb/tb_nmr_bstrm_seq_ctrl.sv
// tb_nmr_bstrm_seq_ctrl: directed scenarios against a table memory and a fixed-latency datapath model
module tb_nmr_bstrm_seq_ctrl;
  localparam int DW = 32, SW = 4, AW = 8, LW = 16, EW = DW + SW + 1;
  logic CLK = 1'b0, RST = 1'b1, seq_start = 1'b0, seq_abort = 1'b0;
  logic [AW:0] seq_len = '0;
  logic [LW-1:0] loop_cnt = '0;
  logic busy, seq_done, aborted, mem_rd, dp_start, dp_pls_pol;
  logic [AW-1:0] cur_idx, mem_addr;
  logic [LW-1:0] loops_done;
  logic [DW-1:0] dp_data;
  logic [SW-1:0] dp_mux_sel;
  logic [EW-1:0] mem_rdata = '0;
  logic [EW-1:0] mem [0:255];
  logic dp_rdy = 1'b1, dp_done = 1'b0;
  int dp_cnt = 0;
  int pass_cnt = 0, total = 0;
  logic prev_start = 1'b0;
  int n_start = 0, n_rd = 0;
  logic [AW-1:0] addr_q[$];
  logic [EW-1:0] op_q[$];

  nmr_bstrm_seq_ctrl dut (
    .CLK(CLK), .RST(RST), .seq_start(seq_start), .seq_abort(seq_abort),
    .seq_len(seq_len), .loop_cnt(loop_cnt), .busy(busy), .seq_done(seq_done),
    .aborted(aborted), .cur_idx(cur_idx), .loops_done(loops_done),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dp_start(dp_start), .dp_rdy(dp_rdy), .dp_done(dp_done), .dp_data(dp_data),
    .dp_pls_pol(dp_pls_pol), .dp_mux_sel(dp_mux_sel)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (mem_rd) mem_rdata <= mem[mem_addr];

  // datapath: one-cycle DONE a fixed number of cycles after START rises
  always @(posedge CLK) begin
    if (!dp_start) begin
      dp_cnt  <= 0;
      dp_done <= 1'b0;
    end else begin
      dp_cnt  <= dp_cnt + 1;
      dp_done <= (dp_cnt == 3);
    end
  end

  always @(posedge CLK) begin
    prev_start <= dp_start;
    if (mem_rd) begin
      n_rd <= n_rd + 1;
      addr_q.push_back(mem_addr);
    end
    if (dp_start && !prev_start) begin
      n_start <= n_start + 1;
      op_q.push_back({dp_pls_pol, dp_mux_sel, dp_data});
    end
  end

  task automatic start_seq(input logic [AW:0] len, input logic [LW-1:0] loops);
    @(negedge CLK);
    seq_len   = len;
    loop_cnt  = loops;
    seq_start = 1'b1;
    @(negedge CLK);
    seq_start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output bit got);
    got = 1'b0;
    for (int i = 0; i < lim && !got; i++) begin
      @(negedge CLK);
      if (seq_done) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if ({busy, seq_done, aborted, mem_rd, dp_start} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {busy, seq_done, aborted, mem_rd, dp_start}); else pass_cnt++;
    total++; if ({cur_idx, loops_done, mem_addr, dp_data, dp_pls_pol, dp_mux_sel} !== '0) $display("FAIL reset_data: got nonzero data outputs"); else pass_cnt++;
    RST = 1'b0;
  endtask

  task automatic test_basic;
    int s_op, s_st;
    bit got;
    s_op = op_q.size();
    s_st = n_start;
    start_seq(3, 1);
    total++; if ({mem_rd, busy, mem_addr} !== {2'b11, 8'd0}) $display("FAIL basic_fetch: got rd=%b busy=%b addr=%0d want 1 1 0", mem_rd, busy, mem_addr); else pass_cnt++;
    @(negedge CLK);
    @(negedge CLK);
    total++; if ({dp_pls_pol, dp_mux_sel, dp_data, dp_start} !== {1'b1, 4'd0, 32'd5, 1'b0}) $display("FAIL basic_latch: got pol=%b sel=%0d data=%0d start=%b want 1 0 5 0", dp_pls_pol, dp_mux_sel, dp_data, dp_start); else pass_cnt++;
    @(negedge CLK);
    total++; if (dp_start !== 1'b1) $display("FAIL basic_start_lat: got %b want 1", dp_start); else pass_cnt++;
    seq_len   = 5;
    seq_start = 1'b1;
    @(negedge CLK);
    seq_start = 1'b0;
    wait_done(300, got);
    total++; if (got !== 1'b1) $display("FAIL basic_done: got %b want 1", got); else pass_cnt++;
    total++; if ({aborted, busy, loops_done} !== {2'b00, 16'd1}) $display("FAIL basic_end: got ab=%b busy=%b loops=%0d want 0 0 1", aborted, busy, loops_done); else pass_cnt++;
    total++; if (n_start - s_st !== 3) $display("FAIL basic_pulses: got %0d want 3", n_start - s_st); else pass_cnt++;
    total++; if (op_q[s_op] !== {1'b1, 4'd0, 32'd5}) $display("FAIL basic_op0: got %h want %h", op_q[s_op], {1'b1, 4'd0, 32'd5}); else pass_cnt++;
    total++; if (op_q[s_op+1] !== {1'b0, 4'd2, 32'd7}) $display("FAIL basic_op1: got %h want %h", op_q[s_op+1], {1'b0, 4'd2, 32'd7}); else pass_cnt++;
    total++; if (op_q[s_op+2] !== {1'b1, 4'd3, 32'd0}) $display("FAIL basic_op2: got %h want %h", op_q[s_op+2], {1'b1, 4'd3, 32'd0}); else pass_cnt++;
    @(negedge CLK);
    total++; if (seq_done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", seq_done); else pass_cnt++;
  endtask

  task automatic test_repeat;
    int s_ad, s_st;
    bit got;
    s_ad = addr_q.size();
    s_st = n_start;
    start_seq(2, 3);
    wait_done(400, got);
    total++; if (got !== 1'b1) $display("FAIL repeat_done: got %b want 1", got); else pass_cnt++;
    total++; if (n_start - s_st !== 6) $display("FAIL repeat_pulses: got %0d want 6", n_start - s_st); else pass_cnt++;
    total++; if (loops_done !== 16'd3) $display("FAIL repeat_loops: got %0d want 3", loops_done); else pass_cnt++;
    total++; if (addr_q.size() - s_ad !== 6) $display("FAIL repeat_reads: got %0d want 6", addr_q.size() - s_ad); else pass_cnt++;
    for (int i = 0; i < 6 && s_ad + i < addr_q.size(); i++) begin
      total++; if (addr_q[s_ad+i] !== AW'(i % 2)) $display("FAIL repeat_addr%0d: got %0d want %0d", i, addr_q[s_ad+i], i % 2); else pass_cnt++;
    end
  endtask

  task automatic test_zero_len;
    int s_rd, s_st;
    s_rd = n_rd;
    s_st = n_start;
    start_seq(0, 1);
    total++; if ({busy, seq_done} !== 2'b10) $display("FAIL zero_finish: got busy=%b done=%b want 1 0", busy, seq_done); else pass_cnt++;
    @(negedge CLK);
    total++; if ({busy, seq_done} !== 2'b01) $display("FAIL zero_done: got busy=%b done=%b want 0 1", busy, seq_done); else pass_cnt++;
    total++; if ({n_rd - s_rd, n_start - s_st} !== {32'd0, 32'd0}) $display("FAIL zero_activity: got rd=%0d start=%0d want 0 0", n_rd - s_rd, n_start - s_st); else pass_cnt++;
  endtask

  task automatic test_ready_gating;
    int high_cnt;
    bit got;
    high_cnt = 0;
    start_seq(1, 1);
    @(negedge CLK);
    dp_rdy = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (dp_start) high_cnt++;
    end
    total++; if (high_cnt !== 0) $display("FAIL rdy_hold: got %0d high cycles want 0", high_cnt); else pass_cnt++;
    dp_rdy = 1'b1;
    @(negedge CLK);
    total++; if (dp_start !== 1'b1) $display("FAIL rdy_rise: got %b want 1", dp_start); else pass_cnt++;
    wait_done(100, got);
    total++; if ({got, aborted} !== 2'b10) $display("FAIL rdy_done: got done=%b ab=%b want 1 0", got, aborted); else pass_cnt++;
  endtask

  task automatic test_abort;
    int s_rd, s_st, w;
    bit got;
    s_rd = n_rd;
    s_st = n_start;
    start_seq(3, 0);
    w = 0;
    while (n_start - s_st < 2 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    total++; if (n_start - s_st !== 2) $display("FAIL abort_reach_run: got %0d pulses want 2", n_start - s_st); else pass_cnt++;
    seq_abort = 1'b1;
    @(negedge CLK);
    total++; if ({dp_start, busy} !== 2'b01) $display("FAIL abort_drop: got start=%b busy=%b want 0 1", dp_start, busy); else pass_cnt++;
    wait_done(50, got);
    total++; if ({got, aborted} !== 2'b11) $display("FAIL abort_done: got done=%b ab=%b want 1 1", got, aborted); else pass_cnt++;
    seq_abort = 1'b0;
    total++; if (n_rd - s_rd !== 2) $display("FAIL abort_reads: got %0d want 2", n_rd - s_rd); else pass_cnt++;
  endtask

  task automatic test_abort_on_done;
    int s_rd, s_st, w;
    bit got;
    s_rd = n_rd;
    s_st = n_start;
    start_seq(3, 0);
    total++; if (aborted !== 1'b0) $display("FAIL abdone_clear: got %b want 0", aborted); else pass_cnt++;
    w = 0;
    while (!(n_start - s_st == 2 && dp_done) && w < 200) begin
      @(negedge CLK);
      w++;
    end
    total++; if ({n_start - s_st, dp_done} !== {32'd2, 1'b1}) $display("FAIL abdone_reach: got pulses=%0d done=%b want 2 1", n_start - s_st, dp_done); else pass_cnt++;
    seq_abort = 1'b1;
    @(negedge CLK);
    total++; if ({dp_start, mem_rd} !== 2'b00) $display("FAIL abdone_drop: got start=%b rd=%b want 0 0", dp_start, mem_rd); else pass_cnt++;
    wait_done(50, got);
    seq_abort = 1'b0;
    total++; if ({got, aborted} !== 2'b11) $display("FAIL abdone_done: got done=%b ab=%b want 1 1", got, aborted); else pass_cnt++;
    total++; if (n_rd - s_rd !== 2) $display("FAIL abdone_reads: got %0d want 2", n_rd - s_rd); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    int w;
    bit got;
    start_seq(2, 1);
    w = 0;
    while (!dp_start && w < 50) begin
      @(negedge CLK);
      w++;
    end
    total++; if (dp_start !== 1'b1) $display("FAIL midrst_run: got %b want 1", dp_start); else pass_cnt++;
    RST = 1'b1;
    @(negedge CLK);
    total++; if ({busy, seq_done, aborted, mem_rd, dp_start, cur_idx, loops_done, dp_data, dp_pls_pol, dp_mux_sel} !== '0) $display("FAIL midrst_outputs: got busy=%b start=%b data=%0d want all 0", busy, dp_start, dp_data); else pass_cnt++;
    RST = 1'b0;
    start_seq(2, 1);
    total++; if ({mem_rd, mem_addr} !== {1'b1, 8'd0}) $display("FAIL midrst_restart: got rd=%b addr=%0d want 1 0", mem_rd, mem_addr); else pass_cnt++;
    wait_done(200, got);
    total++; if ({got, loops_done} !== {1'b1, 16'd1}) $display("FAIL midrst_done: got done=%b loops=%0d want 1 1", got, loops_done); else pass_cnt++;
  endtask

  task automatic test_len_clamp;
    int s_st;
    bit got;
    s_st = n_start;
    start_seq(9'h1FF, 1);
    wait_done(8000, got);
    total++; if (got !== 1'b1) $display("FAIL clamp_done: got %b want 1", got); else pass_cnt++;
    total++; if (n_start - s_st !== 256) $display("FAIL clamp_pulses: got %0d want 256", n_start - s_st); else pass_cnt++;
    total++; if (addr_q[addr_q.size()-1] !== 8'd255) $display("FAIL clamp_last_addr: got %0d want 255", addr_q[addr_q.size()-1]); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {1'b0, 4'd1, 32'd1};
    mem[0] = {1'b1, 4'd0, 32'd5};
    mem[1] = {1'b0, 4'd2, 32'd7};
    mem[2] = {1'b1, 4'd3, 32'd0};
    test_reset;
    test_basic;
    test_repeat;
    test_zero_len;
    test_ready_gating;
    test_abort;
    test_abort_on_done;
    test_reset_mid_run;
    test_len_clamp;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
